// File: rtl/framebuffer_line_fetcher.sv
// Fetches one scan line of RGB565 pixels from the PSRAM framebuffer in fixed-length
// read bursts and writes the returned 64-bit words into one half of a ping-pong line
// buffer. Single clock domain (PSRAM controller clock).
module framebuffer_line_fetcher #(
    parameter int unsigned H_PIXELS    = 1280,
    parameter int unsigned V_LINES     = 720,
    parameter int unsigned BURST_BEATS = 4,
    parameter logic [20:0] BASE_ADDR   = 21'd0,
    parameter int unsigned WORD_AW     = 9
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_line_req,
    input  logic [9:0]         i_line_num,
    input  logic               i_buf_sel,
    output logic               o_busy,
    output logic               o_line_done,
    output logic               o_overrun,
    output logic               o_read_req,
    input  logic               i_read_gnt,
    output logic [20:0]        o_read_addr,
    input  logic [63:0]        i_read_data,
    input  logic               i_read_data_valid,
    output logic               o_lb_we,
    output logic [WORD_AW:0]   o_lb_addr,
    output logic [63:0]        o_lb_data
);

    localparam int unsigned WPL     = H_PIXELS / 4;
    localparam int unsigned NBURST  = WPL / BURST_BEATS;
    localparam int unsigned BEAT_W  = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
    localparam int unsigned BURST_W = (NBURST > 1) ? $clog2(NBURST) : 1;

    localparam logic [BEAT_W-1:0]  LAST_BEAT  = BEAT_W'(BURST_BEATS - 1);
    localparam logic [BURST_W-1:0] LAST_BURST = BURST_W'(NBURST - 1);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWaitData,
        StDone
    } state_e;

    state_e               state_q, state_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 overrun_q, overrun_d;
    logic                 read_req_q, read_req_d;
    logic [20:0]          read_addr_q, read_addr_d;
    logic                 lb_we_q, lb_we_d;
    logic [WORD_AW:0]     lb_addr_q, lb_addr_d;
    logic [63:0]          lb_data_q, lb_data_d;
    logic                 buf_sel_q, buf_sel_d;
    logic [BURST_W-1:0]   burst_q, burst_d;
    logic [WORD_AW-1:0]   word_q, word_d;
    logic [BEAT_W-1:0]    beat_q, beat_d;

    logic [20:0]          line_offset;
    logic                 line_valid;

    // Line base offset wraps modulo 2^21 along with the address space.
    assign line_offset = 21'(i_line_num) * 21'(WPL);
    assign line_valid  = (32'(i_line_num) < V_LINES);

    // Next-state and registered-output logic for the fetch sequencer.
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        overrun_d   = 1'b0;
        read_req_d  = read_req_q;
        read_addr_d = read_addr_q;
        lb_we_d     = 1'b0;
        lb_addr_d   = lb_addr_q;
        lb_data_d   = lb_data_q;
        buf_sel_d   = buf_sel_q;
        burst_d     = burst_q;
        word_d      = word_q;
        beat_d      = beat_q;

        // A request outside IDLE is flagged but never disturbs the running fetch.
        if (i_line_req && (state_q != StIdle)) begin
            overrun_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (i_line_req && line_valid) begin
                    buf_sel_d   = i_buf_sel;
                    read_addr_d = BASE_ADDR + line_offset;
                    burst_d     = '0;
                    word_d      = '0;
                    beat_d      = '0;
                    busy_d      = 1'b1;
                    read_req_d  = 1'b1;
                    state_d     = StReq;
                end
            end
            StReq: begin
                if (i_read_gnt) begin
                    read_req_d = 1'b0;
                    state_d    = StWaitData;
                end
            end
            StWaitData: begin
                if (i_read_data_valid) begin
                    lb_we_d   = 1'b1;
                    lb_addr_d = {buf_sel_q, word_q};
                    lb_data_d = i_read_data;
                    word_d    = word_q + WORD_AW'(1);
                    if (beat_q == LAST_BEAT) begin
                        beat_d = '0;
                        if (burst_q == LAST_BURST) begin
                            state_d = StDone;
                        end else begin
                            burst_d     = burst_q + BURST_W'(1);
                            read_addr_d = read_addr_q + 21'(BURST_BEATS);
                            read_req_d  = 1'b1;
                            state_d     = StReq;
                        end
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            StDone: begin
                // Last write is on the bus this cycle; done and busy-low follow it.
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers; reset aborts any fetch in progress.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= StIdle;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
            read_req_q  <= 1'b0;
            read_addr_q <= '0;
            lb_we_q     <= 1'b0;
            lb_addr_q   <= '0;
            lb_data_q   <= '0;
            buf_sel_q   <= 1'b0;
            burst_q     <= '0;
            word_q      <= '0;
            beat_q      <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            overrun_q   <= overrun_d;
            read_req_q  <= read_req_d;
            read_addr_q <= read_addr_d;
            lb_we_q     <= lb_we_d;
            lb_addr_q   <= lb_addr_d;
            lb_data_q   <= lb_data_d;
            buf_sel_q   <= buf_sel_d;
            burst_q     <= burst_d;
            word_q      <= word_d;
            beat_q      <= beat_d;
        end
    end

    assign o_busy      = busy_q;
    assign o_line_done = done_q;
    assign o_overrun   = overrun_q;
    assign o_read_req  = read_req_q;
    assign o_read_addr = read_addr_q;
    assign o_lb_we     = lb_we_q;
    assign o_lb_addr   = lb_addr_q;
    assign o_lb_data   = lb_data_q;

endmodule

// File: doc/framebuffer_line_fetcher.md
# framebuffer_line_fetcher

Read-side companion to `framebuffer_writer`, sitting between the HDMI video timing logic and the read port of `psram_arb`. On a per-line request it fetches one full scan line of RGB565 pixels from the PSRAM framebuffer in fixed-length bursts. It writes the returned 64-bit words into one half of an external ping-pong line buffer, which the video output then scans out. It runs entirely in the PSRAM controller clock domain (`clk_out` of the PSRAM IP).

## Interface
Parameters:
- `H_PIXELS`, 1280: pixels per line; must be a multiple of 4·`BURST_BEATS`.
- `V_LINES`, 720: valid line numbers are 0..`V_LINES`-1.
- `BURST_BEATS`, 4: 64-bit beats returned per read grant.
- `BASE_ADDR`, 21'd0: PSRAM word address of pixel (0,0).
- `WORD_AW`, 9: line-buffer word index width; must satisfy 2^`WORD_AW` ≥ `H_PIXELS`/4.

Ports:
- `i_clk`  in  1  PSRAM controller clock.
- `i_rst_n`  in  1  reset; asynchronous, active-low.
- `i_line_req`  in  1  single-cycle pulse: fetch line `i_line_num` into half `i_buf_sel`.
- `i_line_num`  in  10  line number, sampled with `i_line_req`.
- `i_buf_sel`  in  1  target line-buffer half, sampled with `i_line_req`.
- `o_busy`  out  1  high from acceptance of a request until `o_line_done`.
- `o_line_done`  out  1  one-cycle pulse when the whole line has been written.
- `o_overrun`  out  1  one-cycle pulse when `i_line_req` arrives while busy.
- `o_read_req`  out  1  read request to `psram_arb`.
- `i_read_gnt`  in  1  one-cycle grant for the current request.
- `o_read_addr`  out  21  PSRAM word address of the burst.
- `i_read_data`  in  64  read data beat: 4 pixels, pixel 0 in bits [15:0].
- `i_read_data_valid`  in  1  beat qualifier.
- `o_lb_we`  out  1  line-buffer write enable.
- `o_lb_addr`  out  `WORD_AW`+1  line-buffer address: {buf_sel, word index}.
- `o_lb_data`  out  64  line-buffer write data.

## Operation
- Derived constants:
  - WPL = `H_PIXELS`/4, the 64-bit words per line.
  - NBURST = WPL/`BURST_BEATS`.
- FSM states: IDLE, REQ, WAIT_DATA, DONE.
- **IDLE**
  - On `i_line_req` with `i_line_num` < `V_LINES`: latch `i_buf_sel`, compute line_base = `BASE_ADDR` + `i_line_num`·WPL (21-bit, modulo 2^21), clear the burst and word counters, then go to REQ.
  - A request with `i_line_num` ≥ `V_LINES` is ignored: no read, no done pulse.
- **REQ**
  - `o_read_req`=1 and `o_read_addr` = line_base + burst_idx·`BURST_BEATS`; both are held stable until `i_read_gnt`.
  - On grant: go to WAIT_DATA.
- **WAIT_DATA**
  - Each `i_read_data_valid` beat is written to the line buffer at word index = word counter, which then increments.
  - After `BURST_BEATS` beats: if burst_idx+1 < NBURST, increment burst_idx and go to REQ; otherwise go to DONE.
- **DONE**: pulse `o_line_done` for one cycle, then return to IDLE.
- Only one burst is outstanding at a time.
- Valid beats arriving outside WAIT_DATA are dropped; `o_lb_we` stays 0.
- `i_line_req` in any state other than IDLE pulses `o_overrun`; the current fetch continues unaffected.
- Reset mid-line: the fetch is aborted immediately; the next request restarts from word 0.

## Timing
- Reset values: every output is 0, the FSM is in IDLE, and all counters are 0.
- Request to read: `i_line_req` in cycle N gives `o_busy`=1 and `o_read_req`=1 from cycle N+1.
- Grant: `o_read_req` drops in the cycle after `i_read_gnt` is sampled high. The next request can assert at the earliest one cycle after the last beat of the previous burst.
- Line-buffer write path: registered. A beat in cycle M produces `o_lb_we`=1 with that beat's address and data in cycle M+1.
- Line done: `o_line_done` pulses in the cycle after the last `o_lb_we`. `o_busy` falls in that same cycle.
- `o_overrun` is asserted in the cycle after the offending `i_line_req`.
- Back-to-back beats, one per cycle, must be absorbed without loss.

## Test plan
- Line 0, buf 0, grant 2 cycles after req, 4 contiguous beats per burst: 80 requests at addresses 0, 4, 8, … 316. 320 writes to `o_lb_addr` 0..319 with matching data. One `o_line_done`.
- Line 719, buf 1: first `o_read_addr` = 230080 (719·320). The last burst is at 230396. `o_lb_addr` spans 512..831 (MSB=1).
- Line 720 requested: no `o_read_req`, `o_busy` stays 0, and no `o_line_done`.
- Second `i_line_req` at word 100 of a fetch: `o_overrun` pulses once. The first line completes with exactly 320 writes and one done pulse.
- Beats gapped randomly (0-3 idle cycles) plus a stray valid while in REQ: the stray beat is not written, and all 320 in-burst words are written in order.
- `i_rst_n` pulsed low mid-burst: all outputs go to 0 at once. A new request for line 5 starts at address 1600 and `o_lb_addr` word 0.
